rom_loader: RTL and testbench

ROM_LOADER -- requirements
Module: rom_loader

---
 rtl/rom_loader.sv | 106 ++++++++++
 tb/tb_rom_loader.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
// Download-to-SDRAM loader: buffers data_io bytes in a small FIFO and replays
// them as one SDRAM write per mem_sync slot, holding the core in reset meanwhile.
module rom_loader #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [24:0] ROM_BASE   = 25'h80000,
  parameter logic [24:0] EXT_BASE   = 25'h68000,
  parameter logic [7:0]  CMOS_INDEX = 8'hff
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        mem_sync,
  output logic        loader_active,
  output logic        loader_we,
  output logic [24:0] loader_addr,
  output logic [7:0]  loader_data,
  output logic        loader_done,
  output logic        overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } entry_t;

  entry_t        fifo_mem [DEPTH];
  entry_t        push_entry;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          download_q;
  logic          active_q;
  logic          accept;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;

  assign accept = ioctl_wr & ioctl_download & (ioctl_index != CMOS_INDEX);
  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign pop    = mem_sync & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the byte.
  assign push   = accept & (~full | pop);

  assign push_entry.addr = ioctl_addr + ((ioctl_index == 8'd0) ? ROM_BASE : EXT_BASE);
  assign push_entry.data = ioctl_dout;

  assign loader_active = ioctl_download | ~empty | loader_we;
  assign loader_done   = active_q & ~loader_active;

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are valid, so flushing them is enough.
  always_ff @(posedge clk_sys) begin
    if (push) fifo_mem[wr_ptr] <= push_entry;
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      loader_we   <= 1'b0;
      loader_addr <= '0;
      loader_data <= '0;
      overflow    <= 1'b0;
      download_q  <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      download_q <= ioctl_download;
      active_q   <= loader_active;

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase

      // Outputs move only at slot boundaries so a write spans one whole slot.
      if (mem_sync) begin
        loader_we <= ~empty;
        if (!empty) begin
          loader_addr <= fifo_mem[rd_ptr].addr;
          loader_data <= fifo_mem[rd_ptr].data;
        end
      end

      if (accept & full & ~pop)
        overflow <= 1'b1;
      else if (ioctl_download & ~download_q)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: directed byte downloads are queued as expected
// SDRAM writes and a slot monitor checks every write the loader presents.
module tb_rom_loader;

  logic        clk_sys;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        mem_sync;
  logic        loader_active;
  logic        loader_we;
  logic [24:0] loader_addr;
  logic [7:0]  loader_data;
  logic        loader_done;
  logic        overflow;

  logic        auto_sync;
  logic        man_sync;
  bit          sync_en;
  int          sync_cnt;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];
  exp_t exp_e;

  int checks;
  int errors;
  int sync_seen;
  int write_count;
  int done_count;
  int wbase;
  int dbase;

  logic        mon_sync;
  logic        mon_rst;
  logic [33:0] prev_out;

  assign mem_sync = auto_sync | man_sync;

  rom_loader dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .mem_sync       (mem_sync),
    .loader_active  (loader_active),
    .loader_we      (loader_we),
    .loader_addr    (loader_addr),
    .loader_data    (loader_data),
    .loader_done    (loader_done),
    .overflow       (overflow)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  // One mem_sync pulse every 8 cycles while enabled.
  initial begin
    auto_sync = 1'b0;
    sync_cnt  = 0;
    forever begin
      @(negedge clk_sys);
      if (sync_en) begin
        sync_cnt  = sync_cnt + 1;
        auto_sync = (sync_cnt % 8 == 0);
      end else begin
        sync_cnt  = 0;
        auto_sync = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Slot monitor: pops the scoreboard on every write, checks hold between slots.
  always @(posedge clk_sys) begin
    mon_sync = mem_sync;
    mon_rst  = reset;
    #1;
    if (!mon_rst) begin
      if (mon_sync) begin
        sync_seen++;
        if (loader_we) begin
          write_count++;
          check("write_expected", 64'(sb.size() != 0), 64'd1);
          if (sb.size() != 0) begin
            exp_e = sb.pop_front();
            check("write_addr", 64'(loader_addr), 64'(exp_e.addr));
            check("write_data", 64'(loader_data), 64'(exp_e.data));
          end
        end
      end else begin
        check("hold_between_slots", 64'({loader_we, loader_addr, loader_data}), 64'(prev_out));
      end
      if (loader_done) done_count++;
    end
    prev_out = {loader_we, loader_addr, loader_data};
  end

  task automatic tick();
    @(negedge clk_sys);
  endtask

  task automatic send_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d,
                           input logic [24:0] exp_a, input bit exp_push);
    ioctl_index = idx;
    ioctl_addr  = a;
    ioctl_dout  = d;
    ioctl_wr    = 1'b1;
    if (exp_push) sb.push_back('{addr: exp_a, data: d});
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_slots(input int n);
    int target;
    target = sync_seen + n;
    for (int i = 0; i < n * 20 + 20 && sync_seen < target; i++) @(negedge clk_sys);
    check("slot_wait_in_budget", 64'(sync_seen >= target), 64'd1);
  endtask

  initial begin
    checks = 0; errors = 0; sync_seen = 0; write_count = 0; done_count = 0;
    reset = 1'b1; ioctl_download = 1'b0; ioctl_index = '0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; man_sync = 1'b0; sync_en = 1'b0;
    repeat (3) tick();

    check("rst_we",       64'(loader_we),     64'd0);
    check("rst_addr",     64'(loader_addr),   64'd0);
    check("rst_data",     64'(loader_data),   64'd0);
    check("rst_done",     64'(loader_done),   64'd0);
    check("rst_overflow", 64'(overflow),      64'd0);
    check("rst_active",   64'(loader_active), 64'd0);
    reset = 1'b0;
    tick();
    ioctl_download = 1'b1;
    tick();
    check("active_on_download", 64'(loader_active), 64'd1);

    // Index 0 path
    sync_en = 1'b1;
    wait_slots(1);
    send_byte(8'd0, 25'h00010, 8'h5A, 25'h80010, 1'b1);
    wait_slots(1);
    check("idx0_we",   64'(loader_we),   64'd1);
    check("idx0_addr", 64'(loader_addr), 64'h80010);
    check("idx0_data", 64'(loader_data), 64'h5A);
    wait_slots(1);
    check("idx0_we_off",    64'(loader_we),   64'd0);
    check("idx0_addr_hold", 64'(loader_addr), 64'h80010);

    // Other-index path, including 25-bit wraparound of the address sum
    send_byte(8'd1, 25'h0000000, 8'hC3, 25'h68000, 1'b1);
    wait_slots(1);
    check("idx1_addr", 64'(loader_addr), 64'h68000);
    check("idx1_data", 64'(loader_data), 64'hC3);
    send_byte(8'd1, 25'h1FFFFFF, 8'h3C, 25'h0067FFF, 1'b1);
    wait_slots(1);
    check("wrap_addr", 64'(loader_addr), 64'h0067FFF);
    wait_slots(1);
    check("wrap_we_off", 64'(loader_we), 64'd0);

    // Overflow: 6 back-to-back bytes into a 4-deep FIFO with no slots
    sync_en = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 6; i++) begin
      send_byte(8'd0, 25'(25'h100 + i), 8'(8'h10 + i), 25'(25'h80100 + i), i < 4);
      if (i == 3) check("ovf_not_yet", 64'(overflow), 64'd0);
    end
    check("ovf_set",      64'(overflow),      64'd1);
    check("ovf_no_write", 64'(loader_we),     64'd0);
    check("ovf_active",   64'(loader_active), 64'd1);
    sync_en = 1'b1;
    wait_slots(4);
    wait_slots(1);
    check("ovf_drained_we", 64'(loader_we), 64'd0);
    check("ovf_sticky",     64'(overflow),  64'd1);

    // Rising edge of ioctl_download clears overflow
    sync_en = 1'b0;
    ioctl_download = 1'b0;
    tick();
    ioctl_download = 1'b1;
    tick();
    check("ovf_cleared", 64'(overflow), 64'd0);

    // Full FIFO with push and pop in the same cycle
    for (int i = 0; i < 4; i++)
      send_byte(8'd0, 25'(25'h200 + i), 8'(8'h20 + i), 25'(25'h80200 + i), 1'b1);
    check("full_no_ovf", 64'(overflow), 64'd0);
    man_sync = 1'b1;
    send_byte(8'd0, 25'h204, 8'h24, 25'h80204, 1'b1);
    man_sync = 1'b0;
    check("pushpop_ovf",  64'(overflow),    64'd0);
    check("pushpop_we",   64'(loader_we),   64'd1);
    check("pushpop_addr", 64'(loader_addr), 64'h80200);
    send_byte(8'd0, 25'h205, 8'h25, 25'h80205, 1'b0);
    check("still_full_ovf", 64'(overflow), 64'd1);
    sync_en = 1'b1;
    wait_slots(4);
    wait_slots(1);
    check("pushpop_drained", 64'(loader_we), 64'd0);

    // Completion: download ends with 2 entries queued
    sync_en = 1'b0;
    repeat (2) tick();
    check("ovf_sticky2", 64'(overflow), 64'd1);
    send_byte(8'd0, 25'h300, 8'h30, 25'h80300, 1'b1);
    send_byte(8'd0, 25'h301, 8'h31, 25'h80301, 1'b1);
    dbase = done_count;
    ioctl_download = 1'b0;
    tick();
    check("done_active_queued", 64'(loader_active), 64'd1);
    sync_en = 1'b1;
    wait_slots(1);
    check("done_slot1_active", 64'(loader_active), 64'd1);
    wait_slots(1);
    check("done_slot2_active", 64'(loader_active), 64'd1);
    check("done_slot2_done",   64'(loader_done),   64'd0);
    wait_slots(1);
    check("done_end_active", 64'(loader_active), 64'd0);
    check("done_pulse",      64'(loader_done),   64'd1);
    tick();
    check("done_pulse_end", 64'(loader_done), 64'd0);
    repeat (3) tick();
    check("done_once", 64'(done_count - dbase), 64'd1);

    // CMOS download: active but never writes
    wbase = write_count;
    ioctl_index = 8'hff;
    ioctl_download = 1'b1;
    tick();
    check("cmos_ovf_cleared", 64'(overflow),      64'd0);
    check("cmos_active",      64'(loader_active), 64'd1);
    for (int i = 0; i < 3; i++) send_byte(8'hff, 25'(i), 8'h77, 25'h0, 1'b0);
    wait_slots(2);
    check("cmos_no_writes",   64'(write_count - wbase), 64'd0);
    check("cmos_active_hold", 64'(loader_active),       64'd1);
    ioctl_download = 1'b0;
    tick();
    check("cmos_inactive", 64'(loader_active), 64'd0);

    // Reset mid-load discards queued bytes
    sync_en = 1'b0;
    repeat (2) tick();
    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    for (int i = 0; i < 3; i++)
      send_byte(8'd0, 25'(25'h400 + i), 8'(8'h40 + i), 25'(25'h80400 + i), 1'b1);
    reset = 1'b1;
    ioctl_download = 1'b0;
    sb.delete();
    tick();
    check("midrst_we",       64'(loader_we),     64'd0);
    check("midrst_addr",     64'(loader_addr),   64'd0);
    check("midrst_data",     64'(loader_data),   64'd0);
    check("midrst_done",     64'(loader_done),   64'd0);
    check("midrst_overflow", 64'(overflow),      64'd0);
    check("midrst_active",   64'(loader_active), 64'd0);
    reset = 1'b0;
    wbase = write_count;
    sync_en = 1'b1;
    wait_slots(3);
    check("midrst_no_writes", 64'(write_count - wbase), 64'd0);
    ioctl_download = 1'b1;
    send_byte(8'd0, 25'h00020, 8'hA5, 25'h80020, 1'b1);
    wait_slots(1);
    check("post_rst_we",   64'(loader_we),   64'd1);
    check("post_rst_addr", 64'(loader_addr), 64'h80020);
    check("post_rst_data", 64'(loader_data), 64'hA5);
    wait_slots(1);
    check("post_rst_we_off", 64'(loader_we), 64'd0);
    ioctl_download = 1'b0;
    tick();
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
